// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : traffic_light_monitor
// Description : Passive checker on the four lamp outputs of the traffic-light
//               controller. It rebuilds the controller's phase index from the
//               observed lamp codes and checks each transition against the
//               18-phase schedule, the required dwell and the cross-road
//               conflict rule.
// Ports       : clk, reset        - clock, asynchronous active-high reset
//               go                - controller count enable (same net)
//               lamps[7:0]        - lamp3..lamp0 codes, 2 bits each
//               clr_err           - synchronous clear of sticky error flags
//               phase[4:0]        - tracked phase 0..17
//               phase_valid       - 1 while locked to the schedule
//               err_seq/err_dwell/err_conflict - sticky error flags
//               cycle_count       - number of legal 17->0 wraps
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [7:0]       lamps,
    input  logic             clr_err,
    output logic [4:0]       phase,
    output logic             phase_valid,
    output logic             err_seq,
    output logic             err_dwell,
    output logic             err_conflict,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [0:0] {
        ST_LOCK = 1'b0,
        ST_HUNT = 1'b1
    } state_t;

    localparam logic [4:0]       C_LAST_PHASE = 5'd17;
    localparam logic [5:0]       C_D_MAX      = 6'd63;
    localparam logic [7:0]       C_RELOCK_PAT = 8'h50;
    localparam logic [CNT_W-1:0] C_CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    // Lamp pattern shown in each phase.
    function automatic logic [7:0] rom_pattern(input logic [4:0] p);
        case (p)
            5'd0:    rom_pattern = 8'h00;
            5'd1:    rom_pattern = 8'h50;
            5'd2:    rom_pattern = 8'hF0;
            5'd3:    rom_pattern = 8'hE0;
            5'd4:    rom_pattern = 8'hC0;
            5'd5:    rom_pattern = 8'h80;
            5'd6:    rom_pattern = 8'h00;
            5'd7:    rom_pattern = 8'h05;
            5'd8:    rom_pattern = 8'h0F;
            5'd9:    rom_pattern = 8'h0E;
            5'd10:   rom_pattern = 8'h0C;
            5'd11:   rom_pattern = 8'h09;
            5'd12:   rom_pattern = 8'h03;
            5'd13:   rom_pattern = 8'h02;
            5'd14:   rom_pattern = 8'h00;
            5'd15:   rom_pattern = 8'h10;
            5'd16:   rom_pattern = 8'h30;
            5'd17:   rom_pattern = 8'h20;
            default: rom_pattern = 8'h00;
        endcase
    endfunction

    // Required dwell of each phase, in counted go cycles.
    function automatic logic [5:0] rom_dwell(input logic [4:0] p);
        case (p)
            5'd0, 5'd6, 5'd14:                          rom_dwell = 6'd1;
            5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11,
            5'd13, 5'd15:                               rom_dwell = 6'd2;
            5'd2:                                       rom_dwell = 6'd30;
            5'd4, 5'd12:                                rom_dwell = 6'd10;
            5'd8, 5'd16:                                rom_dwell = 6'd15;
            5'd10:                                      rom_dwell = 6'd5;
            5'd17:                                      rom_dwell = 6'd3;
            default:                                    rom_dwell = 6'd1;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [4:0]       phase_q, phase_d;
    logic [7:0]       lamps_q, lamps_d;
    logic             go_q, go_d;
    logic [5:0]       d_q, d_d;
    logic             err_seq_q, err_seq_d;
    logic             err_dwell_q, err_dwell_d;
    logic             err_conflict_q, err_conflict_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

    logic       w_change;
    logic       w_conflict;
    logic [4:0] w_next_phase;
    logic [5:0] w_dwell;

    assign w_change     = (lamps != lamps_q);
    assign w_next_phase = (phase_q == C_LAST_PHASE) ? 5'd0 : phase_q + 5'd1;
    assign w_dwell      = rom_dwell(phase_q);
    // Road A is lamps 3/2, road B is lamps 1/0; RED is code 00.
    assign w_conflict   = ((lamps[7:6] != 2'b00) || (lamps[5:4] != 2'b00)) &&
                          ((lamps[3:2] != 2'b00) || (lamps[1:0] != 2'b00));

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        lamps_d        = lamps;
        go_d           = go;
        d_d            = d_q;
        cycle_count_d  = cycle_count_q;
        // Clear first; any set below overrides it (set-dominant flags).
        err_seq_d      = err_seq_q      & ~clr_err;
        err_dwell_d    = err_dwell_q    & ~clr_err;
        err_conflict_d = err_conflict_q & ~clr_err;

        // go_q lines D up with the one-cycle delay between the controller's
        // counter and the lamp change we observe.
        if (w_change) begin
            d_d = 6'd0;
        end else if (go_q && (d_q != C_D_MAX)) begin
            d_d = d_q + 6'd1;
        end

        case (state_q)
            ST_LOCK: begin
                if (w_change) begin
                    if (lamps == rom_pattern(w_next_phase)) begin
                        phase_d = w_next_phase;
                        if (d_q < w_dwell) begin
                            err_dwell_d = 1'b1;
                        end
                        if (phase_q == C_LAST_PHASE) begin
                            cycle_count_d = cycle_count_q + C_CNT_ONE;
                        end
                    end else begin
                        err_seq_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end else if (go_q && (d_q == w_dwell)) begin
                    // D moves past N on this same edge, so an overrun is
                    // flagged only once per phase.
                    err_dwell_d = 1'b1;
                end
            end
            ST_HUNT: begin
                // Pattern 50 occurs only in phase 1, so it is a safe anchor.
                if (w_change && (lamps == C_RELOCK_PAT)) begin
                    state_d = ST_LOCK;
                    phase_d = 5'd1;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        if (w_conflict) begin
            err_conflict_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_LOCK;
            phase_q        <= 5'd0;
            lamps_q        <= 8'h00;
            go_q           <= 1'b0;
            d_q            <= 6'd0;
            err_seq_q      <= 1'b0;
            err_dwell_q    <= 1'b0;
            err_conflict_q <= 1'b0;
            cycle_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            lamps_q        <= lamps_d;
            go_q           <= go_d;
            d_q            <= d_d;
            err_seq_q      <= err_seq_d;
            err_dwell_q    <= err_dwell_d;
            err_conflict_q <= err_conflict_d;
            cycle_count_q  <= cycle_count_d;
        end
    end

    assign phase        = phase_q;
    assign phase_valid  = (state_q == ST_LOCK);
    assign err_seq      = err_seq_q;
    assign err_dwell    = err_dwell_q;
    assign err_conflict = err_conflict_q;
    assign cycle_count  = cycle_count_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_light_monitor
// Description : Self-checking bench for traffic_light_monitor. Directed lamp
//               sequences plus a behavioural controller paired with the
//               monitor on a common reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             go = 1'b1;
    logic             clr_err = 1'b0;
    logic [7:0]       dir_lamps = 8'h00;
    logic             ctrl_en = 1'b0;
    logic [7:0]       lamps;
    logic [4:0]       phase;
    logic             phase_valid;
    logic             err_seq;
    logic             err_dwell;
    logic             err_conflict;
    logic [CNT_W-1:0] cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    traffic_light_monitor #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .lamps        (lamps),
        .clr_err      (clr_err),
        .phase        (phase),
        .phase_valid  (phase_valid),
        .err_seq      (err_seq),
        .err_dwell    (err_dwell),
        .err_conflict (err_conflict),
        .cycle_count  (cycle_count)
    );

    // Schedule table of the controller being watched.
    function automatic logic [7:0] sched_pat(input logic [4:0] p);
        case (p)
            5'd1: sched_pat = 8'h50;  5'd2: sched_pat = 8'hF0;
            5'd3: sched_pat = 8'hE0;  5'd4: sched_pat = 8'hC0;
            5'd5: sched_pat = 8'h80;  5'd7: sched_pat = 8'h05;
            5'd8: sched_pat = 8'h0F;  5'd9: sched_pat = 8'h0E;
            5'd10: sched_pat = 8'h0C; 5'd11: sched_pat = 8'h09;
            5'd12: sched_pat = 8'h03; 5'd13: sched_pat = 8'h02;
            5'd15: sched_pat = 8'h10; 5'd16: sched_pat = 8'h30;
            5'd17: sched_pat = 8'h20;
            default: sched_pat = 8'h00;
        endcase
    endfunction

    function automatic logic [5:0] sched_n(input logic [4:0] p);
        case (p)
            5'd0, 5'd6, 5'd14: sched_n = 6'd1;
            5'd2:              sched_n = 6'd30;
            5'd4, 5'd12:       sched_n = 6'd10;
            5'd8, 5'd16:       sched_n = 6'd15;
            5'd10:             sched_n = 6'd5;
            5'd17:             sched_n = 6'd3;
            default:           sched_n = 6'd2;
        endcase
    endfunction

    // Behavioural controller: holds phase p for N(p)+1 counted go cycles.
    // exp_phase is the controller phase one cycle earlier, which is what the
    // monitor should report after each edge.
    logic [4:0] c_phase;
    logic [5:0] c_cnt;
    logic [4:0] exp_phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_phase   <= 5'd0;
            c_cnt     <= 6'd0;
            exp_phase <= 5'd0;
        end else begin
            exp_phase <= c_phase;
            if (ctrl_en && go) begin
                if (c_cnt == sched_n(c_phase)) begin
                    c_phase <= (c_phase == 5'd17) ? 5'd0 : c_phase + 5'd1;
                    c_cnt   <= 6'd0;
                end else begin
                    c_cnt <= c_cnt + 6'd1;
                end
            end
        end
    end

    assign lamps = ctrl_en ? sched_pat(c_phase) : dir_lamps;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_flags(input string tag, input logic [2:0] exp);
        check_val(tag, 32'({err_seq, err_dwell, err_conflict}), 32'(exp));
    endtask

    // Asserts reset at a negedge, checks the asynchronous reset values, and
    // releases at the following negedge (start of cycle 0).
    task automatic do_reset(input string tag);
        @(negedge clk);
        dir_lamps = 8'h00;
        reset = 1'b1;
        #1;
        check_val({tag, "_phase"}, 32'(phase), 32'd0);
        check_val({tag, "_valid"}, 32'(phase_valid), 32'd1);
        check_flags({tag, "_flags"}, 3'b000);
        check_val({tag, "_count"}, 32'(cycle_count), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives pat for n cycles; returns at the negedge after the n-th edge.
    task automatic hold(input logic [7:0] pat, input int n);
        dir_lamps = pat;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        // ---------------- directed: phase 2 overrun ----------------
        ctrl_en = 1'b0;
        go = 1'b1;
        do_reset("rst0");
        hold(8'h00, 2);
        hold(8'h50, 3);
        hold(8'hF0, 31);
        check_val("ovr_phase", 32'(phase), 32'd2);
        check_val("ovr_before", 32'(err_dwell), 32'd0);
        hold(8'hF0, 1);
        check_val("ovr_after", 32'(err_dwell), 32'd1);
        check_val("ovr_valid", 32'(phase_valid), 32'd1);

        // ---------------- directed: phase 2 left early ----------------
        do_reset("rst1");
        hold(8'h00, 2);
        hold(8'h50, 3);
        hold(8'hF0, 30);
        check_val("early_before", 32'(err_dwell), 32'd0);
        hold(8'hE0, 1);
        check_val("early_dwell", 32'(err_dwell), 32'd1);
        check_val("early_phase", 32'(phase), 32'd3);
        check_val("early_seq", 32'(err_seq), 32'd0);

        // ---------------- directed: skipped phase, relock, clear ----------------
        do_reset("rst2");
        hold(8'h00, 2);
        hold(8'h50, 3);
        check_val("skip_pre_phase", 32'(phase), 32'd1);
        check_flags("skip_pre_flags", 3'b000);
        hold(8'hC0, 1);
        check_val("skip_seq", 32'(err_seq), 32'd1);
        check_val("skip_valid", 32'(phase_valid), 32'd0);
        check_val("skip_phase_hold", 32'(phase), 32'd1);
        hold(8'h00, 1);
        check_val("hunt_valid", 32'(phase_valid), 32'd0);
        hold(8'h50, 1);
        check_val("relock_valid", 32'(phase_valid), 32'd1);
        check_val("relock_phase", 32'(phase), 32'd1);
        clr_err = 1'b1;
        hold(8'h50, 1);
        clr_err = 1'b0;
        check_val("clr_seq", 32'(err_seq), 32'd0);
        check_val("clr_dwell", 32'(err_dwell), 32'd0);

        // ---------------- directed: conflict and set-dominant clear ----------------
        do_reset("rst3");
        hold(8'h83, 1);
        check_val("conf_set", 32'(err_conflict), 32'd1);
        clr_err = 1'b1;
        hold(8'h83, 1);
        check_val("conf_setdom", 32'(err_conflict), 32'd1);
        check_val("conf_seq_clr", 32'(err_seq), 32'd0);
        hold(8'h00, 1);
        clr_err = 1'b0;
        check_val("conf_clr", 32'(err_conflict), 32'd0);

        // ---------------- paired with controller, go = 1 ----------------
        ctrl_en = 1'b1;
        go = 1'b1;
        do_reset("rst4");
        for (int i = 0; i < 310; i++) begin
            @(negedge clk);
            check_val("run_phase", 32'(phase), 32'(exp_phase));
            if (i == 124) check_val("run_count_124", 32'(cycle_count), 32'd0);
            if (i == 125) check_val("run_count_125", 32'(cycle_count), 32'd1);
            if (i == 249) check_val("run_count_249", 32'(cycle_count), 32'd1);
            if (i == 250) check_val("run_count_250", 32'(cycle_count), 32'd2);
        end
        check_flags("run_flags", 3'b000);
        check_val("run_valid", 32'(phase_valid), 32'd1);
        check_val("run_mid8_phase", 32'(phase), 32'd8);

        // Reset in the middle of phase 8, then one clean schedule.
        do_reset("rst_mid8");
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            check_val("post_phase", 32'(phase), 32'(exp_phase));
            if (i == 125) check_val("post_count_125", 32'(cycle_count), 32'd1);
        end
        check_flags("post_flags", 3'b000);

        // ---------------- paired with controller, go toggling ----------------
        do_reset("rst5");
        for (int i = 0; i < 600; i++) begin
            go = (i % 2 == 0);
            @(negedge clk);
            check_val("tog_valid", 32'(phase_valid), 32'd1);
            check_val("tog_phase", 32'(phase), 32'(exp_phase));
        end
        go = 1'b1;
        check_flags("tog_flags", 3'b000);
        check_val("tog_count_ge2", 32'(cycle_count >= 2), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
